rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands by reusing one 4-bit ripple-carry slice, one 4-bit chunk per clock, LSB chunk first.
- The carry is registered between chunks.
- Sits between a valid/ready producer and a valid/ready consumer, giving wide additions at 4-bit adder area.

Parameters:
- WIDTH, 16, operand/sum width. Must be a multiple of 4 and at least 4; any other value is an elaboration-time error.
- NSLICE, WIDTH/4, derived chunk count. Localparam, not user-overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into chunk 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of the top chunk.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0. Internal operand, carry and chunk-counter registers are also cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: capture a, b and cin into internal registers, clear the chunk counter, go to RUN.
- RUN:
  - in_ready=0. In_valid and operand changes are ignored.
  - Each edge T+k (k=1..NSLICE) adds chunk k-1: slice inputs are A_reg[3:0], B_reg[3:0] and carry_reg.
  - The slice sum is shifted into sum_reg from the MSB end. The slice carry goes to carry_reg.
  - A_reg and B_reg shift right by 4.
  - At edge T+NSLICE: cout=slice carry, state goes to DONE.
- DONE:
  - out_valid=1.
  - sum and cout are held stable for as long as out_ready=0.
  - On out_valid&out_ready: go to IDLE; out_valid falls, in_ready rises on the next cycle.
- Latency: out_valid is first seen high NSLICE cycles after the acceptance edge.
- Throughput: one operation per NSLICE+2 cycles minimum.
- Arithmetic: {cout,sum} = a + b + cin, exact and mod 2^(WIDTH+1). No saturation.
- sum and cout are visible only while out_valid=1. Between operations they hold their last value. sum_reg is not exposed mid-RUN: the sum port drives the last completed result.
- Chunk counter width is max(1,$clog2(NSLICE)) and does not wrap in normal operation. The RUN→DONE transition is decoded at count NSLICE-1.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes; the input is accepted no earlier than the following IDLE cycle.
- rst_n low at any time, including mid-RUN or in DONE: immediate return to reset values. The partial result is discarded and no out_valid is produced for the aborted operation.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.

Decomposition:
- Shared package rca_ctrl_pkg:
  - state enum typedef (IDLE, RUN, DONE).
  - localparam SLICE_W=4.
- One sub-module, rca_slice4: a combinational 4-bit ripple-carry slice (a4, b4, ci → s4, co) built from the existing full-adder cell, instantiated once.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, cin=0 → sum=16'h5555, cout=0. out_valid high exactly 4 cycles after the acceptance edge.
- a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1 (carry propagates through all 4 chunks).
- a=16'h8000, b=16'hE000, cin=0 → sum=16'h6000, cout=1; repeat with cin=1 → sum=16'h6001, cout=1.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid, sum and cout stable, in_ready=0, a new in_valid is ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-op: drop rst_n after the 2nd chunk edge → all outputs at reset values immediately. After release, a=16'h00FF, b=16'h0001, cin=0 → sum=16'h0100, cout=0.
- Back-to-back: in_valid held high, out_ready held high, 3 operations → 3 correct results, acceptances spaced 6 cycles apart.

Source files
------------

// File: rtl/rca_ctrl_pkg.sv
// Shared types and the full-adder cell for the chunked ripple-carry adder.
package rca_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-bit full adder cell, result packed as {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/rca_slice4.sv
// Combinational 4-bit ripple-carry slice built from the full-adder cell.
module rca_slice4
  import rca_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               ci,
  output logic [SLICE_W-1:0] s4,
  output logic               co
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s4   = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      {c[i+1], s4[i]} = full_add(a4[i], b4[i], c[i]);
    end
  end

  assign co = c[SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequential WIDTH-bit adder reusing one 4-bit slice, LSB chunk first, one chunk per clock.
// Result appears NSLICE cycles after acceptance and is held until the consumer takes it.
module rca_seq_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
      $error("rca_seq_ctrl: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;

  rca_slice4 u_slice (
    .a4 (a_q[SLICE_W-1:0]),
    .b4 (b_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s4 (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = slice_co;
        acc_d   = (acc_q >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
        cnt_d   = cnt_q + 1'b1;
        // Publish the finished word only on the last chunk so sum never shows partial data.
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          cnt_d   = cnt_q;
          sum_d   = acc_d;
          cout_d  = slice_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl: expected sums queued at acceptance, compared at output handshake.
module tb_rca_seq_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  int               n_checks = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               n_acc = 0;
  int               n_out = 0;
  int               last_acc = 0;
  logic             ov_prev = 1'b0;
  logic [WIDTH:0]   exp_q[$];
  int               acc_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: inputs are driven just after posedge, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin));
        last_acc = cyc + 1;
        acc_cyc.push_back(cyc + 1);
        n_acc++;
      end
      if (out_valid && !ov_prev) check("latency", 32'(cyc - last_acc), NSLICE);
      if (out_valid && out_ready) begin
        check("pending_results", 32'(exp_q.size()), 1);
        if (exp_q.size() != 0) begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e[WIDTH-1:0]));
          check("cout", 32'(cout), 32'(e[WIDTH]));
        end
        n_out++;
      end
      ov_prev = out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  task automatic wait_acc(input int target);
    for (int i = 0; i < 50 && n_acc < target; i++) @(posedge clk);
    check("accept_timeout", 32'(n_acc >= target), 1);
  endtask

  task automatic wait_out(input int target);
    for (int i = 0; i < 50 && n_out < target; i++) @(posedge clk);
    check("output_timeout", 32'(n_out >= target), 1);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    int ta;
    int to;
    ta = n_acc + 1;
    to = n_out + 1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    wait_acc(ta);
    #1 in_valid = 1'b0;
    wait_out(to);
    #1;
  endtask

  logic [WIDTH:0]   bp_exp;
  logic [WIDTH-1:0] b2b_a[3] = '{16'h0001, 16'h7FFF, 16'hC3A5};
  logic [WIDTH-1:0] b2b_b[3] = '{16'h0002, 16'h0001, 16'h5C5B};
  logic             b2b_c[3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int base;
    int to;
    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    do_op(16'h1234, 16'h4321, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1);
    do_op(16'h8000, 16'hE000, 1'b0);
    do_op(16'h8000, 16'hE000, 1'b1);

    // Backpressure: hold the result, offer a new operand that must wait for IDLE.
    out_ready = 1'b0;
    bp_exp = model(16'hABCD, 16'h6543, 1'b1);
    a = 16'hABCD; b = 16'h6543; cin = 1'b1; in_valid = 1'b1;
    wait_acc(n_acc + 1);
    #1 in_valid = 1'b0;
    repeat (NSLICE) @(posedge clk);
    #1 a = 16'h0F0F; b = 16'h0101; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_sum", 32'(sum), 32'(bp_exp[WIDTH-1:0]));
      check("bp_cout", 32'(cout), 32'(bp_exp[WIDTH]));
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_busy", 32'(busy), 1);
    end
    @(posedge clk) #1 out_ready = 1'b1;
    to = n_out + 2;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_out_valid", 32'(out_valid), 0);
    @(posedge clk) #1 in_valid = 1'b0;
    wait_out(to);
    #1;

    // Reset after the second chunk edge of an operation.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    wait_acc(n_acc + 1);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_sum", 32'(sum), 0);
    check("abort_cout", 32'(cout), 0);
    check("abort_busy", 32'(busy), 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    do_op(16'h00FF, 16'h0001, 1'b0);

    // Back-to-back with both valid and ready held high.
    base = n_acc;
    to = n_out + 3;
    a = b2b_a[0]; b = b2b_b[0]; cin = b2b_c[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_acc(base + i + 1);
      #1;
      if (i < 2) begin
        a = b2b_a[i+1]; b = b2b_b[i+1]; cin = b2b_c[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    wait_out(to);
    check("b2b_spacing_1", 32'(acc_cyc[base+1] - acc_cyc[base]), NSLICE + 2);
    check("b2b_spacing_2", 32'(acc_cyc[base+2] - acc_cyc[base+1]), NSLICE + 2);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
